// File: rtl/icache_fetch_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM encoding,
// architectural vectors and address-field width helpers.
package icache_fetch_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } fetch_state_e;

    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0080;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    function automatic int offset_width(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    // Tag covers the word address (30 bits) above index and offset.
    function automatic int tag_width(input int lines, input int words);
        return 30 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/icache_store.sv
// Tag/valid/data storage for the direct-mapped instruction cache:
// one combinational read port, one word write port, a line-fill port and a global clear.
module icache_store
    import icache_fetch_responder_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int IDX_W = index_width(LINES),
    parameter int OFF_W = offset_width(WORDS),
    parameter int TAG_W = tag_width(LINES, WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_offset,
    output logic [31:0]      rd_data,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_offset,
    input  logic [31:0]      wr_data,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             clear_all
);

    logic [31:0]      data_mem [0:LINES*WORDS-1];
    logic [TAG_W-1:0] tag_mem  [0:LINES-1];
    logic [LINES-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                tag_mem[i] <= '0;
            end
        end else if (fill_en) begin
            tag_mem[fill_index] <= fill_tag;
        end
    end

    // A fill completing in the same cycle as a clear still leaves its line valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (clear_all) begin
                valid_q <= '0;
            end
            if (fill_en) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    assign rd_data  = data_mem[{rd_index, rd_offset}];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/icache_fetch_responder.sv
// Fetch-side responder: direct-mapped read-only I-cache with whole-line refill
// over a single-outstanding memory bus, one instruction per cycle on hits.
module icache_fetch_responder
    import icache_fetch_responder_pkg::*;
#(
    parameter int          LINES    = 16,
    parameter int          WORDS    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    input  logic        inv,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic [31:0] resp_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W = offset_width(WORDS);
    localparam int IDX_W = index_width(LINES);
    localparam int TAG_W = tag_width(LINES, WORDS);
    localparam logic [OFF_W-1:0] LAST_K = OFF_W'(WORDS - 1);
    localparam logic [29:0] unused_reset_word = RESET_PC[31:2];

    fetch_state_e     state_q, state_d;
    logic [29:0]      waddr_q, waddr_d;
    logic [OFF_W-1:0] k_q, k_d;
    logic             drop_q, drop_d;
    logic             pending_q, pending_d;
    logic [31:0]      stage_inst_q, stage_inst_d;
    logic [31:0]      stage_addr_q, stage_addr_d;
    logic [31:0]      hold_inst_q, hold_addr_q;

    logic [29:0]      look_word;
    logic [31:0]      rd_data;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             hit;
    logic             accept;
    logic             ack_now;
    logic             last_ack;
    logic             unused_bits;

    assign unused_bits = ^{req_addr[1:0], unused_reset_word};

    // In IDLE the lookup uses the incoming address; elsewhere it reads the
    // line being refilled, so the requested word can be returned at RESPOND.
    assign look_word = (state_q == IDLE) ? req_addr[31:2] : waddr_q;
    assign hit       = rd_valid && (rd_tag == look_word[29 -: TAG_W]);
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign ack_now   = (state_q == REFILL) && mem_ack;
    assign last_ack  = ack_now && (k_q == LAST_K);

    icache_store #(
        .LINES(LINES),
        .WORDS(WORDS),
        .IDX_W(IDX_W),
        .OFF_W(OFF_W),
        .TAG_W(TAG_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (look_word[OFF_W +: IDX_W]),
        .rd_offset (look_word[OFF_W-1:0]),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_en     (ack_now),
        .wr_index  (waddr_q[OFF_W +: IDX_W]),
        .wr_offset (k_q),
        .wr_data   (mem_rdata),
        .fill_en   (last_ack),
        .fill_index(waddr_q[OFF_W +: IDX_W]),
        .fill_tag  (waddr_q[29 -: TAG_W]),
        .clear_all (inv)
    );

    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        k_d          = k_q;
        drop_d       = drop_q;
        pending_d    = 1'b0;
        stage_inst_d = stage_inst_q;
        stage_addr_d = stage_addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    waddr_d = req_addr[31:2];
                    if (hit) begin
                        pending_d    = 1'b1;
                        stage_inst_d = rd_data;
                        stage_addr_d = {req_addr[31:2], 2'b00};
                    end else begin
                        state_d = REFILL;
                        k_d     = '0;
                        drop_d  = 1'b0;
                    end
                end
            end
            REFILL: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (ack_now) begin
                    k_d = k_q + OFF_W'(1);
                end
                if (last_ack) begin
                    state_d = RESPOND;
                    if (!(drop_q || flush)) begin
                        pending_d    = 1'b1;
                        // Requested word may be arriving right now rather than stored.
                        stage_inst_d = (waddr_q[OFF_W-1:0] == k_q) ? mem_rdata : rd_data;
                        stage_addr_d = {waddr_q, 2'b00};
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            k_q          <= '0;
            drop_q       <= 1'b0;
            pending_q    <= 1'b0;
            stage_inst_q <= '0;
            stage_addr_q <= '0;
            hold_inst_q  <= '0;
            hold_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            k_q          <= k_d;
            drop_q       <= drop_d;
            pending_q    <= pending_d;
            stage_inst_q <= stage_inst_d;
            stage_addr_q <= stage_addr_d;
            if (resp_valid) begin
                hold_inst_q <= stage_inst_q;
                hold_addr_q <= stage_addr_q;
            end
        end
    end

    // A flush in the response cycle kills that response; the data outputs then
    // keep showing the last delivered instruction.
    assign resp_valid = pending_q && !flush;
    assign resp_inst  = resp_valid ? stage_inst_q : hold_inst_q;
    assign resp_addr  = resp_valid ? stage_addr_q : hold_addr_q;

    assign mem_req  = (state_q == REFILL);
    assign mem_addr = mem_req ? {waddr_q[29:OFF_W], k_q, 2'b00} : '0;

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Scoreboard bench for icache_fetch_responder: directed fetch sequences against
// a behavioural backing memory with configurable acknowledge latency.
`timescale 1ns/1ps
module tb_icache_fetch_responder;
    import icache_fetch_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        inv = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic [31:0] resp_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] mem_log[$];
    int          resp_cycles[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          lat_cnt = 0;
    int          acks = 0;
    int          resp_count = 0;
    int          last_resp_cyc = 0;
    bit          mem_req_seen = 1'b0;

    icache_fetch_responder #(
        .LINES(16),
        .WORDS(4),
        .RESET_PC(32'hBFC0_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .flush     (flush),
        .inv       (inv),
        .resp_valid(resp_valid),
        .resp_inst (resp_inst),
        .resp_addr (resp_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory: acknowledges after lat cycles of mem_req, drives shortly after the edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n || !mem_req) begin
            mem_ack = 1'b0;
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (lat_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                mem_log.push_back(mem_addr);
                acks++;
                lat_cnt = 0;
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // Monitor: every delivered instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) mem_req_seen = 1'b1;
            if (resp_valid) begin
                resp_count++;
                last_resp_cyc = cyc;
                resp_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got addr %h expected no response", resp_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_addr", resp_addr, e.addr);
                    check("resp_inst", resp_inst, e.inst);
                end
            end
        end
    end

    // Present a request and hold it until accepted; called and returns at posedge+2.
    task automatic fetch(input logic [31:0] a, input bit expect_resp, output int acc_cyc);
        bit took = 1'b0;
        acc_cyc = 0;
        if (expect_resp) exp_q.push_back('{a, mem_word(a)});
        req_valid = 1'b1;
        req_addr  = a;
        for (int n = 0; n < 200 && !took; n++) begin
            @(negedge clk);
            took    = req_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #2;
        end
        req_valid = 1'b0;
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: addr %h not accepted, wanted acceptance", a);
        end
    endtask

    task automatic wait_resps(input int n);
        int t = 0;
        while (resp_count < n && t < 100) begin
            @(posedge clk);
            t++;
        end
        #2;
        check("resp_arrived", 32'(resp_count >= n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int base;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 32'd1);
        check("rst_resp_valid", resp_valid, 32'd0);
        check("rst_resp_inst", resp_inst, 32'd0);
        check("rst_resp_addr", resp_addr, 32'd0);
        check("rst_mem_req", mem_req, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Cold miss, single-cycle ack: 4 reads, response 6 cycles counting acceptance
        mem_log.delete();
        fetch(RESET_VECTOR, 1'b1, acc);
        wait_resps(1);
        check("cold_latency", 32'(last_resp_cyc - acc + 1), 32'd6);
        check("cold_reads", 32'(mem_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < mem_log.size(); i++)
            check("cold_read_addr", mem_log[i], RESET_VECTOR + 32'(4 * i));

        // Back-to-back hits
        mem_req_seen = 1'b0;
        base = resp_count;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back('{RESET_VECTOR + 32'(4 * i), mem_word(RESET_VECTOR + 32'(4 * i))});
            req_valid = 1'b1;
            req_addr  = RESET_VECTOR + 32'(4 * i);
            @(negedge clk);
            check("hit_ready", req_ready, 32'd1);
            @(posedge clk);
            #2;
        end
        req_valid = 1'b0;
        wait_resps(base + 3);
        n = resp_cycles.size();
        if (n >= 3) check("hit_spacing", 32'(resp_cycles[n-1] - resp_cycles[n-3]), 32'd2);
        check("hit_no_mem_req", 32'(mem_req_seen), 32'd0);

        // Flush in IDLE kills the previous hit, accepts the redirect target
        base = resp_count;
        req_valid = 1'b1;
        req_addr  = RESET_VECTOR + 32'h4;
        @(negedge clk);
        @(posedge clk);
        #2;
        flush    = 1'b1;
        req_addr = RESET_VECTOR + 32'h8;
        exp_q.push_back('{RESET_VECTOR + 32'h8, mem_word(RESET_VECTOR + 32'h8)});
        @(negedge clk);
        check("flush_idle_killed", resp_valid, 32'd0);
        @(posedge clk);
        #2;
        flush     = 1'b0;
        req_valid = 1'b0;
        wait_resps(base + 1);

        // Conflict: same index, different tag, then the original misses again
        mem_log.delete();
        fetch(32'hBFC0_0100, 1'b1, acc);
        wait_resps(base + 2);
        check("conflict_reads", 32'(mem_log.size()), 32'd4);
        if (mem_log.size() > 0) check("conflict_addr0", mem_log[0], 32'hBFC0_0100);
        mem_log.delete();
        fetch(RESET_VECTOR, 1'b1, acc);
        wait_resps(base + 3);
        check("conflict_remiss_reads", 32'(mem_log.size()), 32'd4);
        if (mem_log.size() > 3) check("conflict_addr3", mem_log[3], RESET_VECTOR + 32'hC);

        // Flush during the second ack of a refill, redirect presented in the same cycle
        lat  = 2;
        acks = 0;
        base = resp_count;
        fetch(32'h0040_0000, 1'b0, acc);
        n = 0;
        while (!(mem_ack && acks == 2) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("flush_second_ack", 32'(acks), 32'd2);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = EXC_VECTOR;
        @(posedge clk);
        #2;
        flush = 1'b0;
        fetch(EXC_VECTOR, 1'b1, acc);
        wait_resps(base + 1);
        mem_log.delete();
        fetch(32'h0040_0000, 1'b1, acc);
        wait_resps(base + 2);
        check("flushed_line_valid", 32'(mem_log.size()), 32'd0);

        // inv together with a hit: hit served, next fetch refills
        lat = 1;
        base = resp_count;
        exp_q.push_back('{32'h0040_0000, mem_word(32'h0040_0000)});
        req_valid = 1'b1;
        req_addr  = 32'h0040_0000;
        inv       = 1'b1;
        @(negedge clk);
        check("inv_ready", req_ready, 32'd1);
        @(posedge clk);
        #2;
        inv       = 1'b0;
        req_valid = 1'b0;
        wait_resps(base + 1);
        check("inv_hit_reads", 32'(mem_log.size()), 32'd0);
        fetch(32'h0040_0000, 1'b1, acc);
        wait_resps(base + 2);
        check("inv_refill_reads", 32'(mem_log.size()), 32'd4);

        // Reset between acks of a refill
        lat  = 3;
        acks = 0;
        fetch(RESET_VECTOR, 1'b0, acc);
        n = 0;
        while (!(acks == 1 && !mem_ack) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("rst_between_acks", 32'(acks), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", mem_req, 32'd0);
        check("rst_mid_mem_addr", mem_addr, 32'd0);
        check("rst_mid_ready", req_ready, 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        lat = 1;
        @(posedge clk);
        #2;
        mem_log.delete();
        base = resp_count;
        fetch(32'h0040_0000, 1'b1, acc);
        wait_resps(base + 1);
        check("post_rst_miss_reads", 32'(mem_log.size()), 32'd4);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
